scan_rx: RTL and testbench

Receive-side assembler of the serial debug unit; the counterpart of the byte/word print path.
- On a request from the debug controller, accepts raw bytes from the UART receiver over a valid/ready handshake.
- Assembles either one byte or one 32-bit word, sent MSB byte first.
- Returns the result with a one-cycle acknowledge.

---
 rtl/scan_pkg.sv | 21 ++
 rtl/scan_rx_if.sv | 22 ++
 rtl/scan_rx_req_edge_det.sv | 17 +
 rtl/scan_rx.sv | 112 +++++++++++
 tb/tb_scan_rx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared constants and types for the serial debug unit's scan (receive) and print paths.
package scan_pkg;

    // Transfer type, also used by the print path
    localparam logic TYPE_BYTE = 1'b0;
    localparam logic TYPE_WORD = 1'b1;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Byte counter start value: counts down to 0 on the last byte
    function automatic logic [1:0] first_count(input logic typ);
        return (typ == TYPE_WORD) ? 2'(BYTES_PER_WORD - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/scan_rx_if.sv
// Scan receive bus: controller request/result plus UART byte handshake.
// master = controller/UART side, slave = scan_rx block.
interface scan_rx_if;
    logic        req_rx;
    logic        type_rx;
    logic        vld_rx;
    logic [7:0]  d_rx;
    logic        rdy_rx;
    logic [31:0] din_rx;
    logic        ack_rx;
    logic        err_rx;

    modport master (
        output req_rx, type_rx, vld_rx, d_rx,
        input  rdy_rx, din_rx, ack_rx, err_rx
    );

    modport slave (
        input  req_rx, type_rx, vld_rx, d_rx,
        output rdy_rx, din_rx, ack_rx, err_rx
    );
endinterface

// File: rtl/scan_rx_req_edge_det.sv
// Registered rising-edge detector with asynchronous active-high reset.
module req_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);
    logic sig_q;

    // Delay the level by one clock to compare against
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rise = sig & ~sig_q;
endmodule

// File: rtl/scan_rx.sv
// scan_rx: assembles one byte or one MSB-first 32-bit word from the UART
// receiver on request, and returns it with a one-cycle ack.
// Optional macro SCAN_TIMEOUT_EN: abort RECV after TIMEOUT_CYCLES idle clocks
// between accepted bytes, returning 0 with err_rx pulsed alongside ack_rx.
module scan_rx
    import scan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic     clk,
    input  logic     rst,
    scan_rx_if.slave bus
);
    scan_state_e state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        typ_q, typ_nxt;
    logic [31:0] din_q, din_nxt;
    logic        ack_q, err_q;
    logic        err_nxt;
    logic        req_rise;
    logic        rdy;
    logic        accept;
    logic        timeout;

    req_edge_det u_req_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus.req_rx),
        .rise (req_rise)
    );

    assign rdy    = (state == ST_RECV);
    assign accept = bus.vld_rx & rdy;

`ifdef SCAN_TIMEOUT_EN
    localparam int GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] gap_q;

    // Idle-gap counter: held at 0 outside RECV and restarted by every accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        gap_q <= '0;
        else if (!rdy || accept)        gap_q <= '0;
        else if (gap_q != GAP_LIMIT)    gap_q <= gap_q + GAP_W'(1);
    end

    // An accept on the limit edge takes priority over the abort
    assign timeout = rdy & ~accept & (gap_q == GAP_LIMIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State, counter, type and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            typ_q <= TYPE_BYTE;
            din_q <= 32'h0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            typ_q <= typ_nxt;
            din_q <= din_nxt;
            ack_q <= (state_nxt == ST_DONE);
            err_q <= err_nxt;
        end
    end

    // Next-state, byte assembly and abort decision
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        typ_nxt   = typ_q;
        din_nxt   = din_q;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_rise) begin
                    typ_nxt   = bus.type_rx;
                    cnt_nxt   = first_count(bus.type_rx);
                    din_nxt   = 32'h0;
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (accept) begin
                    if (typ_q == TYPE_WORD) din_nxt = {din_q[23:0], bus.d_rx};
                    else                    din_nxt = {24'h0, bus.d_rx};
                    if (cnt == 2'd0) state_nxt = ST_DONE;
                    else             cnt_nxt   = cnt - 2'd1;
                end else if (timeout) begin
                    din_nxt   = 32'h0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rdy_rx = rdy;
    assign bus.din_rx = din_q;
    assign bus.ack_rx = ack_q;
    assign bus.err_rx = err_q;
endmodule

// File: tb/tb_scan_rx.sv
// Directed self-checking bench for scan_rx.
module tb_scan_rx;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;
    int   err_cnt = 0;
    int   a0, e0;

    scan_rx_if sif ();

    scan_rx #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses away from the active edge
    always @(negedge clk) begin
        if (sif.ack_rx) ack_cnt <= ack_cnt + 1;
        if (sif.err_rx) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic typ);
        sif.type_rx = typ;
        sif.req_rx  = 1'b1;
        tick();
        sif.req_rx  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        sif.vld_rx = 1'b1;
        sif.d_rx   = b;
        tick();
        sif.vld_rx = 1'b0;
    endtask

    logic [7:0] w_seq [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] g_seq [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    int         gaps  [4] = '{3, 0, 7, 2};

    initial begin
        rst = 1'b1;
        sif.req_rx = 1'b0; sif.type_rx = 1'b0; sif.vld_rx = 1'b0; sif.d_rx = 8'h0;
        #12;
        chk("rst_rdy", 32'(sif.rdy_rx), 32'd0);
        chk("rst_ack", 32'(sif.ack_rx), 32'd0);
        chk("rst_err", 32'(sif.err_rx), 32'd0);
        chk("rst_din", sif.din_rx, 32'h0);
        rst = 1'b0;
        tick(); tick();

        // Byte scan
        start(1'b0);
        chk("byte_rdy", 32'(sif.rdy_rx), 32'd1);
        send(8'hA5);
        chk("byte_ack", 32'(sif.ack_rx), 32'd1);
        chk("byte_din", sif.din_rx, 32'h000000A5);
        chk("byte_rdy_lo", 32'(sif.rdy_rx), 32'd0);
        tick();
        chk("byte_ack_1cyc", 32'(sif.ack_rx), 32'd0);
        chk("byte_din_hold", sif.din_rx, 32'h000000A5);

        // Word scan, back-to-back bytes
        start(1'b1);
        chk("w_rdy", 32'(sif.rdy_rx), 32'd1);
        sif.vld_rx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("w_ack_early", 32'(sif.ack_rx), 32'd0);
            sif.d_rx = w_seq[i];
            tick();
        end
        sif.vld_rx = 1'b0;
        chk("w_ack", 32'(sif.ack_rx), 32'd1);
        chk("w_din", sif.din_rx, 32'h12345678);
        tick();
        chk("w_ack_1cyc", 32'(sif.ack_rx), 32'd0);
        chk("w_idle", 32'(sif.rdy_rx), 32'd0);

        // Word with gaps and a stray request edge mid-word
        a0 = ack_cnt;
        start(1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                sif.req_rx = 1'b1;
                tick();
                sif.req_rx = 1'b0;
            end
            repeat (gaps[i]) tick();
            send(g_seq[i]);
        end
        chk("g_ack", 32'(sif.ack_rx), 32'd1);
        chk("g_din", sif.din_rx, 32'hDEADBEEF);
        repeat (6) tick();
        chk("g_single_ack", 32'(ack_cnt - a0), 32'd1);
        chk("g_idle", 32'(sif.rdy_rx), 32'd0);

        // vld held while IDLE is not consumed
        sif.vld_rx = 1'b1;
        sif.d_rx   = 8'h55;
        repeat (3) tick();
        chk("v_rdy_idle", 32'(sif.rdy_rx), 32'd0);
        chk("v_ack_idle", 32'(sif.ack_rx), 32'd0);
        start(1'b0);
        chk("v_rdy", 32'(sif.rdy_rx), 32'd1);
        chk("v_din_clr", sif.din_rx, 32'h0);
        tick();
        sif.vld_rx = 1'b0;
        chk("v_ack", 32'(sif.ack_rx), 32'd1);
        chk("v_din", sif.din_rx, 32'h00000055);
        tick();

        // Async reset mid-word
        a0 = ack_cnt;
        start(1'b1);
        send(8'h01);
        send(8'h02);
        #2 rst = 1'b1;
        #1;
        chk("r_rdy", 32'(sif.rdy_rx), 32'd0);
        chk("r_din", sif.din_rx, 32'h0);
        chk("r_ack", 32'(sif.ack_rx), 32'd0);
        #3 rst = 1'b0;
        tick(); tick();
        chk("r_no_ack", 32'(ack_cnt - a0), 32'd0);
        start(1'b1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("r_ack2", 32'(sif.ack_rx), 32'd1);
        chk("r_din2", sif.din_rx, 32'h01020304);
        tick();

        // Stall after one byte of a word
        a0 = ack_cnt;
        e0 = err_cnt;
        start(1'b1);
        send(8'h99);
`ifdef SCAN_TIMEOUT_EN
        begin
            int waited = 0;
            bit found  = 1'b0;
            while (!found && waited < 40) begin
                tick();
                waited++;
                if (sif.ack_rx) found = 1'b1;
            end
            chk("t_wait", 32'(waited), 32'd16);
            chk("t_err", 32'(sif.err_rx), 32'd1);
            chk("t_din", sif.din_rx, 32'h0);
            tick();
            chk("t_err_1cyc", 32'(sif.err_rx), 32'd0);
        end
`else
        repeat (40) tick();
        chk("t_stay_recv", 32'(sif.rdy_rx), 32'd1);
        chk("t_no_err", 32'(err_cnt - e0), 32'd0);
        chk("t_no_ack", 32'(ack_cnt - a0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
